// File: rtl/sb_rx_deframer.sv
// Sideband receive deframer: UART-style bit capture, DLE framing/unstuffing,
// LT transactions as single events and AT transactions as a first/last-marked byte stream.
module sb_rx_deframer #(
  parameter logic [7:0]  DLE          = 8'hFE,
  parameter logic [7:0]  STX_AT       = 8'h05,
  parameter logic [7:0]  ETX          = 8'h40,
  parameter int unsigned MAX_AT_BYTES = 16
) (
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       sbrx,
  output logic       lt_valid,
  output logic [7:0] lt_lse,
  output logic       lt_err,
  output logic       at_valid,
  output logic [7:0] at_data,
  output logic       at_first,
  output logic       at_last,
  output logic       at_err,
  output logic       rx_busy
);

  localparam int unsigned CW = $clog2(MAX_AT_BYTES + 1);

  typedef enum logic [1:0] {B_HUNT, B_DATA, B_STOP} bit_state_e;
  typedef enum logic [2:0] {
    F_IDLE, F_GOT_DLE, F_LT_CLSE, F_LT_DLE, F_LT_ETX, F_AT_DATA, F_AT_ESC
  } frm_state_e;

  bit_state_e    bit_state_q;
  frm_state_e    frm_state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          armed_q;
  logic [7:0]    lse_q;
  logic [7:0]    hold_q;
  logic          hold_full_q;
  logic          first_pend_q;
  logic [CW-1:0] pay_cnt_q;

  logic          lt_valid_q, lt_err_q, at_valid_q, at_err_q, at_first_q, at_last_q;
  logic [7:0]    lt_lse_q, at_data_q;

  logic          stop_ok, stop_bad, pay_stb;

  // The frame layer acts on the byte at the stop-bit edge so results appear
  // in the cycle right after the stop bit.
  always_comb begin
    stop_ok  = (bit_state_q == B_STOP) && sbrx;
    stop_bad = (bit_state_q == B_STOP) && !sbrx;
    pay_stb  = stop_ok &&
               (((frm_state_q == F_AT_DATA) && (shift_q != DLE)) ||
                ((frm_state_q == F_AT_ESC)  && (shift_q == DLE)));
  end

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      bit_state_q  <= B_HUNT;
      frm_state_q  <= F_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      armed_q      <= 1'b0;
      lse_q        <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      first_pend_q <= 1'b0;
      pay_cnt_q    <= '0;
      lt_valid_q   <= 1'b0;
      lt_err_q     <= 1'b0;
      lt_lse_q     <= '0;
      at_valid_q   <= 1'b0;
      at_err_q     <= 1'b0;
      at_first_q   <= 1'b0;
      at_last_q    <= 1'b0;
      at_data_q    <= '0;
    end else begin
      lt_valid_q <= 1'b0;
      lt_err_q   <= 1'b0;
      at_valid_q <= 1'b0;
      at_err_q   <= 1'b0;
      at_first_q <= 1'b0;
      at_last_q  <= 1'b0;
      if (!enable) begin
        bit_state_q <= B_HUNT;
        armed_q     <= 1'b0;
        frm_state_q <= F_IDLE;
        hold_full_q <= 1'b0;
      end else begin
        // A start bit is only accepted after the line has been seen high.
        case (bit_state_q)
          B_HUNT: begin
            if (sbrx) armed_q <= 1'b1;
            else if (armed_q) begin
              bit_state_q <= B_DATA;
              bit_cnt_q   <= '0;
            end
          end
          B_DATA: begin
            shift_q   <= {sbrx, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) bit_state_q <= B_STOP;
          end
          default: begin
            bit_state_q <= B_HUNT;
            if (!sbrx) armed_q <= 1'b0;
          end
        endcase

        if (stop_bad) begin
          if (frm_state_q inside {F_AT_DATA, F_AT_ESC}) at_err_q <= 1'b1;
          if (frm_state_q inside {F_LT_CLSE, F_LT_DLE, F_LT_ETX}) lt_err_q <= 1'b1;
          frm_state_q <= F_IDLE;
          hold_full_q <= 1'b0;
        end else if (stop_ok) begin
          case (frm_state_q)
            F_IDLE: if (shift_q == DLE) frm_state_q <= F_GOT_DLE;
            F_GOT_DLE: begin
              if (shift_q == STX_AT) begin
                frm_state_q  <= F_AT_DATA;
                pay_cnt_q    <= '0;
                hold_full_q  <= 1'b0;
                first_pend_q <= 1'b1;
              end else if ((shift_q == DLE) || (shift_q == ETX)) begin
                frm_state_q <= F_IDLE;
              end else begin
                lse_q       <= shift_q;
                frm_state_q <= F_LT_CLSE;
              end
            end
            F_LT_CLSE: begin
              if (shift_q == ~lse_q) frm_state_q <= F_LT_DLE;
              else begin
                lt_err_q    <= 1'b1;
                frm_state_q <= F_IDLE;
              end
            end
            F_LT_DLE: begin
              if (shift_q == DLE) frm_state_q <= F_LT_ETX;
              else begin
                lt_err_q    <= 1'b1;
                frm_state_q <= F_IDLE;
              end
            end
            F_LT_ETX: begin
              if (shift_q == ETX) begin
                lt_valid_q <= 1'b1;
                lt_lse_q   <= lse_q;
              end else begin
                lt_err_q   <= 1'b1;
              end
              frm_state_q <= F_IDLE;
            end
            F_AT_DATA: if (shift_q == DLE) frm_state_q <= F_AT_ESC;
            F_AT_ESC: begin
              if (shift_q == DLE) begin
                frm_state_q <= F_AT_DATA;
              end else if ((shift_q == ETX) && hold_full_q) begin
                at_valid_q   <= 1'b1;
                at_data_q    <= hold_q;
                at_first_q   <= first_pend_q;
                at_last_q    <= 1'b1;
                frm_state_q  <= F_IDLE;
                hold_full_q  <= 1'b0;
              end else begin
                at_err_q    <= 1'b1;
                frm_state_q <= F_IDLE;
                hold_full_q <= 1'b0;
              end
            end
            default: frm_state_q <= F_IDLE;
          endcase

          // Overrides the AT_ESC -> AT_DATA move when the payload overflows.
          if (pay_stb) begin
            if (pay_cnt_q == CW'(MAX_AT_BYTES)) begin
              at_err_q    <= 1'b1;
              frm_state_q <= F_IDLE;
              hold_full_q <= 1'b0;
            end else begin
              pay_cnt_q   <= pay_cnt_q + CW'(1);
              hold_q      <= shift_q;
              hold_full_q <= 1'b1;
              if (hold_full_q) begin
                at_valid_q   <= 1'b1;
                at_data_q    <= hold_q;
                at_first_q   <= first_pend_q;
                first_pend_q <= 1'b0;
              end
            end
          end
        end
      end
    end
  end

  assign lt_valid = lt_valid_q;
  assign lt_lse   = lt_lse_q;
  assign lt_err   = lt_err_q;
  assign at_valid = at_valid_q;
  assign at_data  = at_data_q;
  assign at_first = at_first_q;
  assign at_last  = at_last_q;
  assign at_err   = at_err_q;
  assign rx_busy  = (frm_state_q != F_IDLE);

endmodule
